// File: rtl/mips_bus_arbiter.sv
// Two-port bus arbiter: instruction fetch and load/store share one
// memory bus with waitrequest stalls and single-cycle completion pulses.
module mips_bus_arbiter #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_accept,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_accept,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RESP_I,
    RESP_D
  } state_e;

  state_e      state_q, state_d;
  logic        last_d_q, last_d_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        i_accept_q, i_accept_d;
  logic        d_accept_q, d_accept_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        free;
  logic        pick_i;
  logic        pick_d;

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    address_d    = address_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    read_d       = read_q;
    write_d      = write_q;
    i_accept_d   = 1'b0;
    d_accept_d   = 1'b0;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    free         = 1'b0;
    pick_i       = 1'b0;
    pick_d       = 1'b0;

    unique case (state_q)
      IDLE: free = 1'b1;
      GRANT_I, GRANT_D: begin
        if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            d_done_d = 1'b1;
            state_d  = IDLE;
            free     = 1'b1;
          end else begin
            state_d = (state_q == GRANT_I) ? RESP_I : RESP_D;
          end
        end
      end
      RESP_I: begin
        i_rdata_d = readdata;
        i_done_d  = 1'b1;
        state_d   = IDLE;
        free      = 1'b1;
      end
      RESP_D: begin
        d_rdata_d = readdata;
        d_done_d  = 1'b1;
        state_d   = IDLE;
        free      = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A free bus samples requests on the same edge that finishes a transfer
    if (free) begin
      pick_i = i_req &&
               (!d_req || (PRIORITY_MODE == 0 && last_d_q));
      pick_d = d_req && !pick_i;
      if (pick_i) begin
        address_d    = i_addr;
        writedata_d  = '0;
        byteenable_d = 4'hF;
        read_d       = 1'b1;
        write_d      = 1'b0;
        i_accept_d   = 1'b1;
        last_d_d     = 1'b0;
        state_d      = GRANT_I;
      end else if (pick_d) begin
        address_d    = d_addr;
        writedata_d  = d_writedata;
        byteenable_d = d_byteenable;
        read_d       = !d_write;
        write_d      = d_write;
        d_accept_d   = 1'b1;
        last_d_d     = 1'b1;
        state_d      = GRANT_D;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_d_q     <= 1'b1;
      address_q    <= '0;
      writedata_q  <= '0;
      byteenable_q <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      i_accept_q   <= 1'b0;
      d_accept_q   <= 1'b0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      read_q       <= read_d;
      write_q      <= write_d;
      i_accept_q   <= i_accept_d;
      d_accept_q   <= d_accept_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign i_accept   = i_accept_q;
  assign d_accept   = d_accept_q;
  assign i_done     = i_done_q;
  assign d_done     = d_done_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign address    = address_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign read       = read_q;
  assign write      = write_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: both priority modes against a
// transaction-level model, plus directed literal checks.
module tb_mips_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : m
    localparam bit PM = (g == 1);

    logic        reset, i_req, d_req, d_write, waitrequest;
    logic [31:0] i_addr, d_addr, d_writedata, readdata;
    logic [3:0]  d_byteenable;
    logic        i_accept, i_done, d_accept, d_done;
    logic        write, read, busy;
    logic [31:0] i_rdata, d_rdata, address, writedata;
    logic [3:0]  byteenable;

    mips_bus_arbiter #(.PRIORITY_MODE(g)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_accept(i_accept),
      .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr),
      .d_writedata(d_writedata), .d_byteenable(d_byteenable),
      .d_accept(d_accept), .d_done(d_done), .d_rdata(d_rdata),
      .address(address), .write(write), .read(read),
      .waitrequest(waitrequest), .writedata(writedata),
      .byteenable(byteenable), .readdata(readdata), .busy(busy)
    );

    // Bus slave memory: 64 words at addr[7:2]
    logic [31:0] mem [0:63];
    logic        rd_pend;
    logic [5:0]  rd_idx;
    logic [31:0] mask;
    assign mask = {{8{byteenable[3]}}, {8{byteenable[2]}},
                   {8{byteenable[1]}}, {8{byteenable[0]}}};

    always @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < 64; i++)
          mem[i] <= 32'h1234_0000 + 32'(i) * 32'h0101_0101;
        mem[0]  <= 32'h3C08_BFC0;
        mem[12] <= 32'hFFFF_FFFE;
      end else if (write && !waitrequest) begin
        mem[address[7:2]] <= (mem[address[7:2]] & ~mask) |
                             (writedata & mask);
      end
      rd_pend <= !reset && read && !waitrequest;
      rd_idx  <= address[7:2];
    end

    always @(negedge clk)
      readdata <= rd_pend ? mem[rd_idx] : $urandom;

    // Transaction model: 0 = bus free, 1 = strobing, 2 = awaiting data
    int          m_act;
    bit          m_port, m_we, m_last;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_be;
    bit          e_ia, e_da, e_id, e_dd, e_rd, e_wr, e_busy;
    logic [31:0] e_ir, e_dr;

    task automatic model_step();
      bit free, pd;
      if (reset) begin
        m_act = 0; m_last = 1'b1;
        e_ia = 0; e_da = 0; e_id = 0; e_dd = 0;
        e_ir = '0; e_dr = '0;
      end else begin
        e_ia = 0; e_da = 0; e_id = 0; e_dd = 0;
        free = 1'b0;
        if (m_act == 1) begin
          if (!waitrequest) begin
            if (m_we) begin
              e_dd = 1; m_act = 0; free = 1'b1;
            end else begin
              m_act = 2;
            end
          end
        end else if (m_act == 2) begin
          if (m_port) begin
            e_dr = mem[m_addr[7:2]]; e_dd = 1;
          end else begin
            e_ir = mem[m_addr[7:2]]; e_id = 1;
          end
          m_act = 0; free = 1'b1;
        end else begin
          free = 1'b1;
        end
        if (free && (i_req || d_req)) begin
          if (i_req && d_req) pd = PM ? 1'b1 : !m_last;
          else pd = d_req;
          m_act = 1; m_port = pd; m_last = pd;
          if (pd) begin
            m_we = d_write; m_addr = d_addr;
            m_wd = d_writedata; m_be = d_byteenable; e_da = 1;
          end else begin
            m_we = 1'b0; m_addr = i_addr;
            m_wd = '0; m_be = 4'hF; e_ia = 1;
          end
        end
      end
      e_rd   = (m_act == 1) && !m_we;
      e_wr   = (m_act == 1) && m_we;
      e_busy = (m_act != 0);
    endtask

    task automatic lc(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      chk($sformatf("m%0d %s", g, nm), a, e);
    endtask

    task automatic cmp();
      lc("i_accept", i_accept, e_ia);
      lc("d_accept", d_accept, e_da);
      lc("i_done", i_done, e_id);
      lc("d_done", d_done, e_dd);
      lc("read", read, e_rd);
      lc("write", write, e_wr);
      lc("busy", busy, e_busy);
      lc("i_rdata", i_rdata, e_ir);
      lc("d_rdata", d_rdata, e_dr);
      if (e_rd || e_wr) begin
        lc("address", address, m_addr);
        lc("byteenable", byteenable, m_be);
        lc("writedata", writedata, m_wd);
      end
    endtask

    task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cmp();
      if (i_accept) i_req = 1'b0;
      if (d_accept) d_req = 1'b0;
    endtask

    task automatic drain();
      waitrequest = 1'b0;
      for (int k = 0; k < 60 && (busy || i_req || d_req); k++) cyc();
      lc("drain_idle", {busy, i_req, d_req}, 3'b000);
    endtask

    initial begin
      logic [3:0] order;
      int n;
      reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_write = 1'b0;
      i_addr = 32'hBFC0_0000; d_addr = 32'hBFC0_0030;
      d_writedata = '0; d_byteenable = 4'hF; waitrequest = 1'b0;

      repeat (2) begin
        cyc();
        lc("rst_outs", {read, write, busy, i_accept, d_accept,
                        i_done, d_done}, 7'b0);
        lc("rst_addr", address, 32'h0);
        lc("rst_wd", writedata, 32'h0);
        lc("rst_be", byteenable, 32'h0);
        lc("rst_rdata", i_rdata | d_rdata, 32'h0);
      end
      reset = 1'b0;
      cyc();
      lc("first_grant", {i_accept, d_accept}, PM ? 2'b01 : 2'b10);
      drain();

      i_addr = 32'hBFC0_0000; i_req = 1'b1;
      cyc();
      lc("fetch_read", read, 1);
      lc("fetch_addr", address, 32'hBFC0_0000);
      lc("fetch_be", byteenable, 4'hF);
      cyc();
      cyc();
      lc("fetch_done", i_done, 1);
      lc("fetch_rdata", i_rdata, 32'h3C08_BFC0);
      drain();

      d_write = 1'b1; d_addr = 32'hBFC0_002C;
      d_writedata = 32'h0000_000A; d_byteenable = 4'hF;
      d_req = 1'b1; waitrequest = 1'b1;
      for (int k = 0; k < 4; k++) begin
        cyc();
        lc("stall_write", write, 1);
        lc("stall_addr", address, 32'hBFC0_002C);
        lc("stall_wd", writedata, 32'h0000_000A);
        if (k == 3) waitrequest = 1'b0;
      end
      cyc();
      lc("stall_done", d_done, 1);
      lc("stall_wr_low", write, 0);
      lc("stall_mem", mem[11], 32'h0000_000A);
      d_write = 1'b0;
      drain();

      d_addr = 32'hBFC0_0030; d_byteenable = 4'b0010; d_req = 1'b1;
      cyc();
      lc("lane_read", read, 1);
      lc("lane_be", byteenable, 4'b0010);
      cyc();
      cyc();
      lc("lane_done", d_done, 1);
      lc("lane_rdata", d_rdata, 32'hFFFF_FFFE);
      drain();

      i_addr = 32'hBFC0_0004; d_addr = 32'hBFC0_0008;
      d_byteenable = 4'hF; i_req = 1'b1; d_req = 1'b1;
      order = '0; n = 0;
      for (int k = 0; k < 60 && n < 4; k++) begin
        cyc();
        if (i_accept || d_accept) begin
          order[n] = d_accept;
          n++;
        end
        if (n < 4) begin
          i_req = !i_accept; d_req = !d_accept;
        end else begin
          i_req = 1'b0; d_req = 1'b0;
        end
      end
      lc("arb_count", n, 4);
      lc("arb_order", order, PM ? 4'b1111 : 4'b1010);
      drain();

      d_write = 1'b1; d_addr = 32'hBFC0_0010; d_req = 1'b1;
      waitrequest = 1'b1;
      cyc();
      lc("mid_write", write, 1);
      cyc();
      reset = 1'b1;
      cyc();
      lc("mid_write_low", write, 0);
      lc("mid_busy", busy, 0);
      lc("mid_no_done", d_done, 0);
      reset = 1'b0; waitrequest = 1'b0;
      cyc();
      lc("mid_no_done2", d_done, 0);
      d_write = 1'b0;

      for (int k = 0; k < 600; k++) begin
        waitrequest = ($urandom_range(0, 3) == 0);
        if (!i_req && $urandom_range(0, 2) == 0) begin
          i_req = 1'b1;
          i_addr = 32'hBFC0_0000 | (32'($urandom_range(0, 63)) << 2);
        end
        if (!d_req && $urandom_range(0, 2) == 0) begin
          d_req = 1'b1;
          d_write = 1'($urandom);
          d_addr = 32'hBFC0_0000 | (32'($urandom_range(0, 63)) << 2);
          d_writedata = $urandom;
          d_byteenable = 4'($urandom);
        end
        cyc();
      end
      drain();
      done_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && done_cnt < 2; t++) @(posedge clk);
    chk("all_done", done_cnt, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
